// File: rtl/img_pkg.sv
// Shared types for the image-pipeline frame scheduler.
//   sched_state_e : scheduler FSM states
//   err_code_e    : error reason reported on err_code
//   ERR_*         : raw encodings of the error reasons
package img_pkg;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SHORT   = 2'd1;
  localparam logic [1:0] ERR_EXTRA   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_SOF,
    FRAME,
    WAIT_SRC,
    ERR
  } sched_state_e;

  typedef enum logic [1:0] {
    EC_NONE    = ERR_NONE,
    EC_SHORT   = ERR_SHORT,
    EC_EXTRA   = ERR_EXTRA,
    EC_TIMEOUT = ERR_TIMEOUT
  } err_code_e;

endpackage

// File: rtl/edge_det.sv
// Registered rising-edge detector.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   din   : level input
//   rise  : high for one cycle, the cycle after din is first sampled high
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic prev_q, prev_d;
  logic rise_q, rise_d;

  always_comb begin
    prev_d = din;
    rise_d = din & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/img_frame_sched.sv
// Frame-level scheduler: starts the video source, counts filter output
// pixels against the programmed resolution, repeats for N frames and
// reports completion, pixel-count errors and stall timeouts.
//   clk, rst_n              : clock, synchronous active-low reset
//   cfg_start / cfg_abort   : run control
//   cfg_frame_num           : frames per run
//   cfg_xres / cfg_yres     : expected active resolution
//   src_begin / src_done    : video source handshake
//   post_img_vsync / _valid : filter output frame timing
//   busy, done, err, err_code, frame_cnt, pix_cnt : status
module img_frame_sched
  import img_pkg::*;
#(
  parameter int BEGIN_LEN = 5,
  parameter int TIMEOUT   = 2000000,
  parameter int TO_W      = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic        cfg_abort,
  input  logic [7:0]  cfg_frame_num,
  input  logic [15:0] cfg_xres,
  input  logic [15:0] cfg_yres,
  output logic        src_begin,
  input  logic        src_done,
  input  logic        post_img_vsync,
  input  logic        post_img_valid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [7:0]  frame_cnt,
  output logic [31:0] pix_cnt
);

  sched_state_e    state_q, state_d;
  logic [3:0]      begin_cnt_q, begin_cnt_d;
  logic [31:0]     pix_cnt_q, pix_cnt_d;
  logic [31:0]     exp_pix_q, exp_pix_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic [7:0]      frame_num_q, frame_num_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  err_code_e       err_code_q, err_code_d;
  logic            done_q, done_d;
  logic            src_begin_q, src_begin_d;

  logic            vs_rise;
  logic            wd_expired;
  logic [31:0]     pix_inc;
  logic [7:0]      frame_inc;

  edge_det u_vs_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (post_img_vsync),
    .rise (vs_rise)
  );

  assign pix_inc    = pix_cnt_q + 32'd1;
  assign frame_inc  = frame_cnt_q + 8'd1;
  // The cycle whose increment would reach TIMEOUT trips the watchdog.
  assign wd_expired = (wd_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    begin_cnt_d = '0;
    pix_cnt_d   = pix_cnt_q;
    exp_pix_d   = exp_pix_q;
    frame_cnt_d = frame_cnt_q;
    frame_num_d = frame_num_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    done_d      = 1'b0;

    if (cfg_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_start) begin
            if (cfg_frame_num == 8'd0) begin
              done_d = 1'b1;
            end else begin
              err_d       = 1'b0;
              err_code_d  = EC_NONE;
              frame_cnt_d = '0;
              pix_cnt_d   = '0;
              exp_pix_d   = 32'(cfg_xres) * 32'(cfg_yres);
              frame_num_d = cfg_frame_num;
              state_d     = ARM;
            end
          end
        end
        ARM: begin
          if (begin_cnt_q == 4'(BEGIN_LEN - 1)) state_d = WAIT_SOF;
          else                                  begin_cnt_d = begin_cnt_q + 4'd1;
        end
        WAIT_SOF: begin
          // Valids before start-of-frame are blanking and are not counted.
          if (vs_rise) begin
            pix_cnt_d = '0;
            state_d   = FRAME;
          end else if (!post_img_valid && wd_expired) begin
            err_d = 1'b1; err_code_d = EC_TIMEOUT; state_d = ERR;
          end
        end
        FRAME: begin
          if (post_img_valid) pix_cnt_d = pix_inc;
          // A final pixel coinciding with the next vsync edge still completes.
          if (post_img_valid && pix_inc == exp_pix_q) begin
            state_d = WAIT_SRC;
          end else if (vs_rise) begin
            err_d = 1'b1; err_code_d = EC_SHORT; state_d = ERR;
          end else if (!post_img_valid && wd_expired) begin
            err_d = 1'b1; err_code_d = EC_TIMEOUT; state_d = ERR;
          end
        end
        WAIT_SRC: begin
          if (post_img_valid) begin
            err_d = 1'b1; err_code_d = EC_EXTRA; state_d = ERR;
          end else if (src_done) begin
            frame_cnt_d = frame_inc;
            if (frame_inc == frame_num_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = ARM;
            end
          end else if (wd_expired) begin
            err_d = 1'b1; err_code_d = EC_TIMEOUT; state_d = ERR;
          end
        end
        ERR: begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (state_d != state_q || post_img_valid)
      wd_d = '0;
    else if (state_q == WAIT_SOF || state_q == FRAME || state_q == WAIT_SRC)
      wd_d = wd_q + TO_W'(1);
    else
      wd_d = '0;

    // Registered so src_begin is high on exactly the cycles spent in ARM.
    src_begin_d = (state_d == ARM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      begin_cnt_q <= '0;
      pix_cnt_q   <= '0;
      exp_pix_q   <= '0;
      frame_cnt_q <= '0;
      frame_num_q <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      err_code_q  <= EC_NONE;
      done_q      <= 1'b0;
      src_begin_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      begin_cnt_q <= begin_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      exp_pix_q   <= exp_pix_d;
      frame_cnt_q <= frame_cnt_d;
      frame_num_q <= frame_num_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      done_q      <= done_d;
      src_begin_q <= src_begin_d;
    end
  end

  assign src_begin = src_begin_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign frame_cnt = frame_cnt_q;
  assign pix_cnt   = pix_cnt_q;

endmodule
